timer_unit_presc_multi: RTL and testbench

TIMER_UNIT_PRESC_MULTI -- requirements
Module: timer_unit_presc_multi

---
 rtl/timer_presc_pkg.sv | 14 +
 rtl/timer_presc_channel.sv | 78 +++++++
 rtl/timer_unit_presc_multi.sv | 40 ++++
 tb/tb_timer_unit_presc_multi.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_presc_pkg.sv
// Shared definitions for the multi-channel prescaler timer: channel FSM states
// and default sizing constants.
package timer_presc_pkg;

    localparam int TP_NUM_CH_DEF = 2;
    localparam int TP_CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chan_state_e;

endpackage

// File: rtl/timer_presc_channel.sv
// One prescaler channel: counts while enabled, pulses and wraps to zero on a
// compare match, and optionally parks in DONE after the first match.
module timer_presc_channel
    import timer_presc_pkg::*;
#(
    parameter int CNT_W = TP_CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             reset_count_i,
    input  logic             enable_count_i,
    input  logic             oneshot_i,
    input  logic [CNT_W-1:0] compare_value_i,
    input  logic             write_counter_i,
    input  logic [CNT_W-1:0] counter_value_i,
    output logic [CNT_W-1:0] counter_value_o,
    output logic             target_reached_o,
    output logic             done_o
);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_q, tgt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = 1'b0;
        if (reset_count_i) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else if (write_counter_i) begin
            cnt_d   = counter_value_i;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_DONE: begin
                    cnt_d = '0;
                end
                default: begin
                    // IDLE and RUN both count on an enabled edge, so the first
                    // enabled edge after any stop already advances the counter.
                    if (!enable_count_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                        if (cnt_q == compare_value_i) begin
                            cnt_d = '0;
                            tgt_d = 1'b1;
                            if (oneshot_i) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    assign counter_value_o  = cnt_q;
    assign target_reached_o = tgt_q;
    assign done_o           = (state_q == ST_DONE);

endmodule

// File: rtl/timer_unit_presc_multi.sv
// Array of independent prescaler channels sharing one clock and reset, with
// packed per-channel compare/load/counter buses.
module timer_unit_presc_multi
    import timer_presc_pkg::*;
#(
    parameter int NUM_CH = TP_NUM_CH_DEF,
    parameter int CNT_W  = TP_CNT_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH-1:0]       reset_count_i,
    input  logic [NUM_CH-1:0]       enable_count_i,
    input  logic [NUM_CH-1:0]       oneshot_i,
    input  logic [NUM_CH*CNT_W-1:0] compare_value_i,
    input  logic [NUM_CH-1:0]       write_counter_i,
    input  logic [NUM_CH*CNT_W-1:0] counter_value_i,
    output logic [NUM_CH*CNT_W-1:0] counter_value_o,
    output logic [NUM_CH-1:0]       target_reached_o,
    output logic [NUM_CH-1:0]       done_o
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        timer_presc_channel #(
            .CNT_W(CNT_W)
        ) u_channel (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .reset_count_i   (reset_count_i[gi]),
            .enable_count_i  (enable_count_i[gi]),
            .oneshot_i       (oneshot_i[gi]),
            .compare_value_i (compare_value_i[gi*CNT_W +: CNT_W]),
            .write_counter_i (write_counter_i[gi]),
            .counter_value_i (counter_value_i[gi*CNT_W +: CNT_W]),
            .counter_value_o (counter_value_o[gi*CNT_W +: CNT_W]),
            .target_reached_o(target_reached_o[gi]),
            .done_o          (done_o[gi])
        );
    end

endmodule

// File: tb/tb_timer_unit_presc_multi.sv
// Self-checking bench for timer_unit_presc_multi: directed scenarios followed by
// random traffic, all checked against a per-channel behavioural model.
module tb_timer_unit_presc_multi;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic               clk = 1'b0;
    logic               rst_ni = 1'b0;
    logic [NCH-1:0]     rc = '0, en = '0, os = '0, wr = '0;
    logic [NCH*W-1:0]   cmp = '0, ld = '0;
    logic [NCH*W-1:0]   cnt_o;
    logic [NCH-1:0]     tgt_o, done_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: counter value, pulse flag, and whether a one-shot has expired.
    int m_cnt [NCH];
    bit m_tgt [NCH];
    bit m_done[NCH];

    timer_unit_presc_multi #(.NUM_CH(NCH), .CNT_W(W)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .reset_count_i   (rc),
        .enable_count_i  (en),
        .oneshot_i       (os),
        .compare_value_i (cmp),
        .write_counter_i (wr),
        .counter_value_i (ld),
        .counter_value_o (cnt_o),
        .target_reached_o(tgt_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s ch%0d observed=%0d expected=%0d", tag, ch, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int ch);
        return {24'd0, cnt_o[ch*W +: W]};
    endfunction

    function automatic int cmp_of(input int ch);
        return int'(cmp[ch*W +: W]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_tgt[c] = 0; m_done[c] = 0;
        end
    endtask

    // Applies the rules for one rising edge using the inputs as they stand.
    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            if (rc[c]) begin
                m_cnt[c] = 0; m_tgt[c] = 0; m_done[c] = 0;
            end else if (wr[c]) begin
                m_cnt[c] = int'(ld[c*W +: W]); m_tgt[c] = 0; m_done[c] = 0;
            end else if (m_done[c]) begin
                m_cnt[c] = 0; m_tgt[c] = 0;
            end else if (en[c] && m_cnt[c] == cmp_of(c)) begin
                m_cnt[c] = 0; m_tgt[c] = 1; m_done[c] = os[c];
            end else if (en[c]) begin
                m_cnt[c] = (m_cnt[c] + 1) % (1 << W); m_tgt[c] = 0;
            end else begin
                m_tgt[c] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            chk("counter", c, cnt_of(c), m_cnt[c]);
            chk("target",  c, {31'd0, tgt_o[c]}, {31'd0, m_tgt[c]});
            chk("done",    c, {31'd0, done_o[c]}, {31'd0, m_done[c]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_cmp(input int ch, input int v);
        cmp[ch*W +: W] = v[W-1:0];
    endtask

    task automatic clear_all();
        rc = '1; en = '0; wr = '0; os = '0;
        tick();
        rc = '0;
    endtask

    initial begin
        int exp_c0[8];
        int exp_t0[8];
        int pulses;
        int idx;
        bit found;

        model_reset();
        #12;
        check_all();
        rst_ni = 1'b1;

        // Continuous counting, compares 3/1/2/0: ch0 follows a fixed table.
        exp_c0 = '{1, 2, 3, 0, 1, 2, 3, 0};
        exp_t0 = '{0, 0, 0, 1, 0, 0, 0, 1};
        set_cmp(0, 3); set_cmp(1, 1); set_cmp(2, 2); set_cmp(3, 0);
        en = '1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("seq_cnt", 0, cnt_of(0), exp_c0[i]);
            chk("seq_tgt", 0, {31'd0, tgt_o[0]}, exp_t0[i]);
            if (i > 0) chk("cmp0_held", 3, {31'd0, tgt_o[3]}, 32'd1);
        end
        for (int i = 0; i < 12; i++) tick();

        // One-shot on ch0 with compare 5, then reload with 2.
        clear_all();
        os[0] = 1'b1; set_cmp(0, 5); en = '1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tgt_o[0]) pulses++;
        end
        chk("oneshot_pulses", 0, pulses, 32'd1);
        chk("oneshot_done", 0, {31'd0, done_o[0]}, 32'd1);
        chk("oneshot_hold", 0, cnt_of(0), 32'd0);
        wr[0] = 1'b1; ld[0*W +: W] = 8'd2;
        tick();
        wr = '0;
        chk("reload_done", 0, {31'd0, done_o[0]}, 32'd0);
        tick();
        chk("resume_cnt", 0, cnt_of(0), 32'd3);
        os = '0;

        // Compare lowered from 200 to 10 at counter 50 on ch1.
        clear_all();
        set_cmp(1, 200); en = '1;
        for (int i = 0; i < 60 && m_cnt[1] != 50; i++) tick();
        chk("reach50", 1, cnt_of(1), 32'd50);
        set_cmp(1, 10);
        found = 0; idx = 0;
        for (int i = 1; i <= 300 && !found; i++) begin
            tick();
            if (tgt_o[1]) begin found = 1; idx = i; end
        end
        chk("wrap_first_pulse", 1, idx, 32'd217);

        // Reset and write together on the edge that would match on ch2.
        clear_all();
        set_cmp(2, 3); en = '1;
        for (int i = 0; i < 10 && m_cnt[2] != 3; i++) tick();
        rc[2] = 1'b1; wr[2] = 1'b1; ld[2*W +: W] = 8'd7;
        tick();
        chk("rc_wr_cnt", 2, cnt_of(2), 32'd0);
        chk("rc_wr_tgt", 2, {31'd0, tgt_o[2]}, 32'd0);
        rc = '0; wr = '0;
        tick();
        chk("restart_cnt", 2, cnt_of(2), 32'd1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                en[c] = ($urandom % 8) != 0;
                rc[c] = ($urandom % 40) == 0;
                wr[c] = ($urandom % 30) == 0;
                ld[c*W +: W] = 8'($urandom);
                if (($urandom % 16) == 0) os[c] = $urandom % 2;
                if (($urandom % 20) == 0)
                    set_cmp(c, (($urandom % 4) == 0) ? int'($urandom % 256) : int'($urandom % 8));
            end
            tick();
        end

        // Asynchronous reset pulse between edges mid-run.
        rc = '0; wr = '0; os = '0; en = '1;
        set_cmp(0, 1); set_cmp(1, 2); set_cmp(2, 3); set_cmp(3, 0);
        for (int i = 0; i < 7; i++) tick();
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        for (int c = 0; c < NCH; c++) begin
            chk("async_cnt", c, cnt_of(c), 32'd0);
            chk("async_tgt", c, {31'd0, tgt_o[c]}, 32'd0);
            chk("async_done", c, {31'd0, done_o[c]}, 32'd0);
        end
        #3 rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
